// File: rtl/alu_pipe.sv
// alu_pipe: pipelined CU ALU. One registered execute stage (S1) feeds an OUT_DEPTH-entry result FIFO.
// Optional iterative multiplier for op 37 is enabled by defining ALU_MUL_EN.
module alu_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             soc_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [XLEN-1:0]  in_dat1,
  input  logic [XLEN-1:0]  in_dat2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_overflow,
  output logic             out_con_met,
  output logic             out_zero,
  output logic             out_err
);

  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MSB   = XLEN - 1;

  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_BGE   = 6'd7;
  localparam logic [5:0] OP_BLTU  = 6'd8;
  localparam logic [5:0] OP_BGEU  = 6'd9;
  localparam logic [5:0] OP_ADD_A = 6'd18;
  localparam logic [5:0] OP_SLT_A = 6'd19;
  localparam logic [5:0] OP_XOR_A = 6'd21;
  localparam logic [5:0] OP_OR_A  = 6'd22;
  localparam logic [5:0] OP_AND_A = 6'd23;
  localparam logic [5:0] OP_SLL_A = 6'd24;
  localparam logic [5:0] OP_SRL_A = 6'd25;
  localparam logic [5:0] OP_SRA_A = 6'd26;
  localparam logic [5:0] OP_ADD_B = 6'd27;
  localparam logic [5:0] OP_SUB   = 6'd28;
  localparam logic [5:0] OP_SLL_B = 6'd29;
  localparam logic [5:0] OP_SLT_B = 6'd30;
  localparam logic [5:0] OP_SLTU  = 6'd31;
  localparam logic [5:0] OP_XOR_B = 6'd32;
  localparam logic [5:0] OP_SRL_B = 6'd33;
  localparam logic [5:0] OP_SRA_B = 6'd34;
  localparam logic [5:0] OP_OR_B  = 6'd35;
  localparam logic [5:0] OP_AND_B = 6'd36;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic             overflow;
    logic             con_met;
    logic             zero;
    logic             err;
  } res_t;

  // Execute stage registers
  logic             s1_valid;
  logic [5:0]       s1_op;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [TAG_W-1:0] s1_tag;

  // Result FIFO
  res_t             buf_mem [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             in_ready_q;

  logic             accept;
  logic             pop;
  logic             buf_space;
  logic             s1_push;
  logic             s1_load;
  logic             s1_valid_n;
  logic             push;
  logic [CNT_W-1:0] count_n;
  logic             ready_n;
  res_t             push_data;
  res_t             exec_res;
  res_t             mul_res;
  logic             mul_start;
  logic             mul_push;
  logic             mul_idle_n;

  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  diff;
  logic [SH_W-1:0]  shamt;
  logic             cond;
  logic             is_cmp;

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign buf_space = (count < CNT_W'(OUT_DEPTH)) || pop;

  assign sum   = s1_a + s1_b;
  assign diff  = s1_a - s1_b;
  assign shamt = s1_b[SH_W-1:0];

  // Branch and set-less-than conditions
  always_comb begin
    cond   = 1'b0;
    is_cmp = 1'b1;
    case (s1_op)
      OP_BEQ:                     cond = (s1_a == s1_b);
      OP_BNE:                     cond = (s1_a != s1_b);
      OP_BLT, OP_SLT_A, OP_SLT_B: cond = ($signed(s1_a) < $signed(s1_b));
      OP_BGE:                     cond = ($signed(s1_a) >= $signed(s1_b));
      OP_BLTU, OP_SLTU:           cond = (s1_a < s1_b);
      OP_BGEU:                    cond = (s1_a >= s1_b);
      default:                    is_cmp = 1'b0;
    endcase
  end

  always_comb begin
    exec_res     = '0;
    exec_res.tag = s1_tag;
    case (s1_op)
      OP_ADD_A, OP_ADD_B: begin
        exec_res.result   = sum;
        exec_res.overflow = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        exec_res.result   = diff;
        exec_res.overflow = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_SLL_A, OP_SLL_B: exec_res.result = s1_a << shamt;
      OP_SRL_A, OP_SRL_B: exec_res.result = s1_a >> shamt;
      OP_SRA_A, OP_SRA_B: exec_res.result = $signed(s1_a) >>> shamt;
      OP_XOR_A, OP_XOR_B: exec_res.result = s1_a ^ s1_b;
      OP_OR_A,  OP_OR_B:  exec_res.result = s1_a | s1_b;
      OP_AND_A, OP_AND_B: exec_res.result = s1_a & s1_b;
      default: begin
        if (is_cmp) begin
          exec_res.result  = {{(XLEN-1){1'b0}}, cond};
          exec_res.con_met = cond;
        end else begin
          exec_res.err = 1'b1;
        end
      end
    endcase
    exec_res.zero = (exec_res.result == '0);
  end

`ifdef ALU_MUL_EN
  localparam logic [5:0] OP_MUL = 6'd37;

  typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_t;

  mul_state_t       mul_state;
  logic [XLEN-1:0]  mul_a;
  logic [XLEN-1:0]  mul_b;
  logic [XLEN-1:0]  mul_acc;
  logic [SH_W:0]    mul_cnt;
  logic [TAG_W-1:0] mul_tag;

  assign mul_start  = accept && (in_op == OP_MUL);
  assign mul_push   = (mul_state == MUL_RUN) && (mul_cnt == (SH_W+1)'(XLEN)) && buf_space;
  assign mul_idle_n = (mul_state == MUL_IDLE) ? !mul_start : mul_push;

  always_comb begin
    mul_res        = '0;
    mul_res.result = mul_acc;
    mul_res.tag    = mul_tag;
    mul_res.zero   = (mul_acc == '0);
  end

  // Shift-add multiplier: one multiplier bit per cycle, then wait for FIFO room
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      mul_state <= MUL_IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
      mul_tag   <= '0;
    end else begin
      case (mul_state)
        MUL_IDLE: begin
          if (mul_start) begin
            mul_a     <= in_dat1;
            mul_b     <= in_dat2;
            mul_acc   <= '0;
            mul_cnt   <= '0;
            mul_tag   <= in_tag;
            mul_state <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mul_cnt != (SH_W+1)'(XLEN)) begin
            mul_acc <= mul_acc + (mul_b[0] ? mul_a : '0);
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + (SH_W+1)'(1);
          end else if (buf_space) begin
            mul_state <= MUL_IDLE;
          end
        end
        default: mul_state <= MUL_IDLE;
      endcase
    end
  end
`else
  assign mul_start  = 1'b0;
  assign mul_push   = 1'b0;
  assign mul_idle_n = 1'b1;
  assign mul_res    = '0;
`endif

  assign s1_push    = s1_valid && buf_space;
  assign s1_load    = accept && !mul_start;
  assign s1_valid_n = s1_load ? 1'b1 : (s1_push ? 1'b0 : s1_valid);
  assign push       = s1_push || mul_push;
  assign push_data  = mul_push ? mul_res : exec_res;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + CNT_W'(1);
    else if (!push && pop) count_n = count - CNT_W'(1);
  end

  // in_ready is registered from the next-cycle occupancy so it is low throughout reset
  assign ready_n  = ((count_n + CNT_W'(s1_valid_n)) < CNT_W'(OUT_DEPTH)) && mul_idle_n;
  assign in_ready = in_ready_q;

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      s1_valid   <= s1_valid_n;
      count      <= count_n;
      in_ready_q <= ready_n;
      if (s1_load) begin
        s1_op  <= in_op;
        s1_a   <= in_dat1;
        s1_b   <= in_dat2;
        s1_tag <= in_tag;
      end
      if (push) begin
        buf_mem[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign out_result   = buf_mem[rd_ptr].result;
  assign out_tag      = buf_mem[rd_ptr].tag;
  assign out_overflow = buf_mem[rd_ptr].overflow;
  assign out_con_met  = buf_mem[rd_ptr].con_met;
  assign out_zero     = buf_mem[rd_ptr].zero;
  assign out_err      = buf_mem[rd_ptr].err;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a driver queues model results on accept, a monitor checks them on retire.
module tb_alu_pipe;

  logic        soc_clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_dat1;
  logic [31:0] in_dat2;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_overflow;
  logic        out_con_met;
  logic        out_zero;
  logic        out_err;

  typedef logic [39:0] rsp_t;

  rsp_t exp_q[$];
  rsp_t held;
  bit   hold_v   = 0;
  bit   rand_rdy = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_pipe #(.XLEN(32), .OUT_DEPTH(2), .TAG_W(4)) dut (
    .soc_clk(soc_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dat1(in_dat1), .in_dat2(in_dat2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_overflow(out_overflow), .out_con_met(out_con_met),
    .out_zero(out_zero), .out_err(out_err)
  );

  initial begin
    soc_clk = 0;
    forever #5 soc_clk = ~soc_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: result and flags straight from the opcode table using wide arithmetic
  function automatic rsp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag);
    longint      sa, sbv, s;
    logic [63:0] p;
    logic [31:0] r;
    bit          ov, con, err, cmp;
    int          sh;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = int'(b[4:0]);
    r = 0; ov = 0; con = 0; err = 0; cmp = 0;
    case (op)
      6'd4:                begin cmp = 1; con = (a == b);   end
      6'd5:                begin cmp = 1; con = (a != b);   end
      6'd6, 6'd19, 6'd30:  begin cmp = 1; con = (sa < sbv); end
      6'd7:                begin cmp = 1; con = (sa >= sbv); end
      6'd8, 6'd31:         begin cmp = 1; con = (a < b);    end
      6'd9:                begin cmp = 1; con = (a >= b);   end
      6'd18, 6'd27:        begin s = sa + sbv; r = s[31:0]; ov = (s != longint'($signed(r))); end
      6'd28:               begin s = sa - sbv; r = s[31:0]; ov = (s != longint'($signed(r))); end
      6'd24, 6'd29:        r = a << sh;
      6'd25, 6'd33:        r = a >> sh;
      6'd26, 6'd34:        begin s = sa >>> sh; r = s[31:0]; end
      6'd21, 6'd32:        r = a ^ b;
      6'd22, 6'd35:        r = a | b;
      6'd23, 6'd36:        r = a & b;
`ifdef ALU_MUL_EN
      6'd37:               begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
`endif
      default:             err = 1;
    endcase
    if (cmp) r = {31'd0, con};
    return {r, tag, ov, con, (r == 32'd0), err};
  endfunction

  function automatic rsp_t actual();
    return {out_result, out_tag, out_overflow, out_con_met, out_zero, out_err};
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    int waited = 0;
    bit done   = 0;
    in_valid = 1; in_op = op; in_dat1 = a; in_dat2 = b; in_tag = tag;
    while (!done) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(model(op, a, b, tag));
        done = 1;
      end else if (waited > 500) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout op=%0d actual=in_ready_low required=accept", op);
        done = 1;
      end
      @(negedge soc_clk);
      waited++;
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int w = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || out_valid) && w < 300) begin
      @(negedge soc_clk);
      #3;
      w++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(negedge soc_clk);
  endtask

  // Monitor: checks retiring results against the scoreboard and output stability under stall
  initial begin
    rsp_t act;
    forever begin
      @(negedge soc_clk);
      #2;
      if (!reset) begin
        hold_v = 0;
      end else begin
        act = actual();
        if (hold_v) check("out_stable", {out_valid, act}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out actual=%h required=no_output", act);
          end else begin
            check("result", act, exp_q.pop_front());
          end
          hold_v = 0;
        end else if (out_valid) begin
          held   = act;
          hold_v = 1;
        end else begin
          hold_v = 0;
        end
      end
    end
  end

  always @(negedge soc_clk) if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);

  initial begin
    logic [5:0]  ops [27] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd18, 6'd19, 6'd21,
                              6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
                              6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
                              6'd40, 6'd63};
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] a, b;

    reset = 0; in_valid = 0; in_op = 0; in_dat1 = 0; in_dat2 = 0; in_tag = 0; out_ready = 0;
    repeat (2) @(negedge soc_clk);
    #1 check("reset_outputs", {23'd0, out_valid, in_ready, actual()}, 64'd0);
    @(negedge soc_clk);
    reset = 1;
    #1 check("ready_low_at_release", {63'd0, in_ready}, 64'd0);
    @(negedge soc_clk);
    #1 check("ready_rise", {63'd0, in_ready}, 64'd1);
    @(negedge soc_clk);

    // Arithmetic corners and back-to-back compares/shift
    out_ready = 1;
    send(6'd18, 32'h7FFF_FFFF, 32'h1, 4'h1);
    send(6'd28, 32'd5, 32'd5, 4'h2);
    send(6'd6,  32'hFFFF_FFFF, 32'd1, 4'h3);
    send(6'd9,  32'd1, 32'hFFFF_FFFF, 4'h4);
    send(6'd26, 32'h8000_0000, 32'd4, 4'h5);
    drain();

    // Backpressure with a two-entry buffer
    out_ready = 0;
    send(6'd22, 32'h0F0F_0000, 32'h0000_F0F0, 4'h6);
    send(6'd23, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'h7);
    #1 check("ready_low_full", {63'd0, in_ready}, 64'd0);
    @(negedge soc_clk);
    repeat (3) @(negedge soc_clk);
    #1 check("ready_held_low", {62'd0, in_ready, out_valid}, 64'd1);
    @(negedge soc_clk);
    out_ready = 1;
    send(6'd21, 32'hAAAA_5555, 32'hFFFF_0000, 4'h8);
    drain();

    // Unsupported opcode, then a normal op
    send(6'd40, 32'h1234_5678, 32'h9ABC_DEF0, 4'hA);
    send(6'd18, 32'd3, 32'd4, 4'hB);
    drain();

    // Op 37
`ifdef ALU_MUL_EN
    send(6'd37, 32'd7, 32'd6, 4'hC);
    for (int i = 0; i < 30; i++) begin
      #1 check("mul_ready_low", {63'd0, in_ready}, 64'd0);
      @(negedge soc_clk);
    end
`else
    send(6'd37, 32'd7, 32'd6, 4'hC);
`endif
    drain();

    // Reset with two buffered entries, then first-op latency
    out_ready = 0;
    send(6'd18, 32'd100, 32'd1, 4'h1);
    send(6'd28, 32'd100, 32'd1, 4'h2);
    @(negedge soc_clk);
    #3 reset = 0;
    hold_v = 0;
    exp_q.delete();
    #1 check("reset_mid_outputs", {62'd0, out_valid, in_ready}, 64'd0);
    @(negedge soc_clk);
    reset = 1;
    @(negedge soc_clk);
    #1 check("ready_after_mid_reset", {63'd0, in_ready}, 64'd1);
    @(negedge soc_clk);
    out_ready = 1;
    send(6'd18, 32'd10, 32'd20, 4'h3);
    #1 check("latency_one_edge", {63'd0, out_valid}, 64'd0);
    @(negedge soc_clk);
    #1 check("latency_two_edges", {63'd0, out_valid}, 64'd1);
    @(negedge soc_clk);
    drain();

    // Randomised traffic with random downstream stalls
    rand_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      send(ops[$urandom_range(0, 26)], a, b, 4'($urandom));
      if ($urandom_range(0, 4) == 0) @(negedge soc_clk);
    end
    rand_rdy = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
